// File: rtl/stage_if_prefetch_pkg.sv
// Shared constants for the instruction fetch stage: default bus widths, reset PC, PC step.
package stage_if_prefetch_pkg;
  localparam int unsigned IF_ADDR_W    = 32;
  localparam int unsigned IF_INST_W    = 32;
  localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;
  localparam int unsigned IF_INST_STEP = 4;
endpackage

// File: rtl/stage_if_prefetch_if_fifo.sv
// Generic FIFO with synchronous flush and occupancy count; read data is the head, combinational.
// Push while full and pop while empty are ignored; flush overrides push and pop.
module if_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/stage_if_prefetch.sv
// Pipelined instruction fetch with prefetch queue; 1-cycle response-to-decode latency (0 with IF_QUEUE_BYPASS_EN).
// Issue throttled by queue space reserved per request; decode stalls via Out_Ready, Feedback_Mem_Acc blocks issue and pop.
module stage_if_prefetch
  import stage_if_prefetch_pkg::*;
#(
  parameter int unsigned         ADDR_W          = IF_ADDR_W,
  parameter int unsigned         INST_W          = IF_INST_W,
  parameter int unsigned         QDEPTH          = 4,
  parameter int unsigned         MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0]   RESET_PC        = ADDR_W'(IF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] PC,
  output logic              Inst_Req_Valid,
  input  logic              Inst_Req_Ready,
  input  logic [INST_W-1:0] Instruction,
  input  logic              Inst_Valid,
  output logic              Inst_Ready,
  output logic [INST_W-1:0] IR,
  output logic [ADDR_W-1:0] IR_PC,
  output logic              Done_O,
  input  logic              Out_Ready,
  input  logic [ADDR_W-1:0] next_PC,
  input  logic              Feedback_Branch,
  input  logic              Feedback_Mem_Acc
);
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned TW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QW = INST_W + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     q_count;
  logic [TW-1:0]     tag_count;
  logic [QW-1:0]     q_rdata;
  logic [ADDR_W-1:0] tag_rdata;
  logic [CW:0]       occupancy;
  logic              q_empty, issue, resp, live, byp, pop_any, q_push, q_pop;

  assign q_empty   = (q_count == '0);
  assign occupancy = {1'b0, q_count} + {1'b0, outstanding_q};

  // Space for every in-flight response is reserved here, so the queue can never overflow.
  assign Inst_Req_Valid = rst && !Feedback_Mem_Acc
                       && (outstanding_q < CW'(MAX_OUTSTANDING))
                       && (occupancy < (CW + 1)'(QDEPTH));
  assign Inst_Ready = rst;
  assign PC         = pc_q;

  always_comb begin
    issue = Inst_Req_Valid && Inst_Req_Ready;
    resp  = Inst_Valid && Inst_Ready && (tag_count != '0);
    live  = resp && (discard_q == '0);

    pc_d = pc_q;
    if (issue) pc_d = pc_q + ADDR_W'(IF_INST_STEP);
    outstanding_d = outstanding_q + CW'(issue) - CW'(resp);
    discard_d     = discard_q - CW'(resp && (discard_q != '0));
    if (Feedback_Branch) begin
      pc_d      = next_PC;
      discard_d = outstanding_d;
    end

`ifdef IF_QUEUE_BYPASS_EN
    byp = q_empty && live && !Feedback_Branch;
`else
    byp = 1'b0;
`endif

    Done_O = !q_empty || byp;
    IR     = '0;
    IR_PC  = '0;
    if (!q_empty) begin
      IR    = q_rdata[QW-1:ADDR_W];
      IR_PC = q_rdata[ADDR_W-1:0];
    end else if (byp) begin
      IR    = Instruction;
      IR_PC = tag_rdata;
    end

    pop_any = Done_O && Out_Ready && !Feedback_Mem_Acc && !Feedback_Branch;
    q_pop   = pop_any && !q_empty;
    q_push  = live && !Feedback_Branch && !(byp && pop_any);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  if_fifo #(.W(QW), .DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst),
    .push  (q_push),
    .wdata ({Instruction, tag_rdata}),
    .pop   (q_pop),
    .flush (Feedback_Branch),
    .rdata (q_rdata),
    .count (q_count)
  );

  // Tags are never flushed: stale ones retire alongside their discarded responses.
  if_fifo #(.W(ADDR_W), .DEPTH(MAX_OUTSTANDING)) u_tags (
    .clk   (clk),
    .rst_n (rst),
    .push  (issue),
    .wdata (pc_q),
    .pop   (resp),
    .flush (1'b0),
    .rdata (tag_rdata),
    .count (tag_count)
  );
endmodule

// File: tb/tb_stage_if_prefetch.sv
// Directed bench for stage_if_prefetch with a queue-based reference model and a 1-cycle memory.
module tb_stage_if_prefetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC, Instruction, IR, IR_PC, next_PC;
  logic        Inst_Req_Valid, Inst_Req_Ready, Inst_Valid, Inst_Ready;
  logic        Done_O, Out_Ready, Feedback_Branch, Feedback_Mem_Acc;

  always #5 clk = ~clk;

  stage_if_prefetch dut (
    .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid),
    .Inst_Req_Ready(Inst_Req_Ready), .Instruction(Instruction), .Inst_Valid(Inst_Valid),
    .Inst_Ready(Inst_Ready), .IR(IR), .IR_PC(IR_PC), .Done_O(Done_O), .Out_Ready(Out_Ready),
    .next_PC(next_PC), .Feedback_Branch(Feedback_Branch), .Feedback_Mem_Acc(Feedback_Mem_Acc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: buffered PCs awaiting decode, requests in flight (with drop flag), delivered log.
  logic [31:0] buf_q[$];
  logic [31:0] infl_pc[$];
  bit          infl_drop[$];
  logic [31:0] deliv[$];
  logic [31:0] m_pc;
  logic [31:0] mem_pc[$];
  int          mem_t[$];

  bit          rst_v, ordy_v, acc_v, br_v, hold_v, rrdy_v;
  logic [31:0] tgt_v;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    buf_q.delete(); infl_pc.delete(); infl_drop.delete();
    mem_pc.delete(); mem_t.delete();
    m_pc = 32'h0;
  endtask

  task automatic cycle();
    bit exp_req, exp_done, iss, rsp, pop, drop;
    logic [31:0] p;
    @(negedge clk);
    rst              = rst_v;
    Out_Ready        = ordy_v;
    Feedback_Mem_Acc = acc_v;
    Feedback_Branch  = br_v;
    next_PC          = tgt_v;
    Inst_Req_Ready   = rrdy_v;
    if (!rst_v) begin
      mem_pc.delete(); mem_t.delete();
    end
    if (rst_v && !hold_v && mem_pc.size() > 0 && mem_t[0] < cyc) begin
      Inst_Valid  = 1'b1;
      Instruction = inst_of(mem_pc[0]);
    end else begin
      Inst_Valid  = 1'b0;
      Instruction = 32'h0;
    end
    #1;
    if (rst_v) begin
      exp_req  = !acc_v && infl_pc.size() < 2 && (buf_q.size() + infl_pc.size()) < 4;
      exp_done = buf_q.size() > 0;
      chk("req_vld", {31'b0, Inst_Req_Valid}, {31'b0, exp_req});
      chk("pc", PC, m_pc);
      chk("done", {31'b0, Done_O}, {31'b0, exp_done});
      chk("inst_rdy", {31'b0, Inst_Ready}, 32'd1);
      if (exp_done) begin
        chk("ir_pc", IR_PC, buf_q[0]);
        chk("ir", IR, inst_of(buf_q[0]));
      end
      iss = exp_req && rrdy_v;
      rsp = Inst_Valid && infl_pc.size() > 0;
      pop = exp_done && ordy_v && !acc_v && !br_v;
      if (pop) begin
        deliv.push_back(buf_q[0]);
        void'(buf_q.pop_front());
      end
      if (rsp) begin
        p    = infl_pc.pop_front();
        drop = infl_drop.pop_front();
        if (!drop && !br_v) buf_q.push_back(p);
      end
      if (iss) begin
        infl_pc.push_back(m_pc);
        infl_drop.push_back(1'b0);
        m_pc = m_pc + 32'd4;
      end
      if (br_v) begin
        foreach (infl_drop[i]) infl_drop[i] = 1'b1;
        buf_q.delete();
        m_pc = tgt_v;
      end
      if (Inst_Valid) begin
        void'(mem_pc.pop_front());
        void'(mem_t.pop_front());
      end
      if (Inst_Req_Valid && Inst_Req_Ready) begin
        mem_pc.push_back(PC);
        mem_t.push_back(cyc);
      end
    end
    cyc++;
    @(posedge clk);
  endtask

  initial begin
    int mark;
    logic [31:0] ir0, pc0;
    rst = 1'b0; Out_Ready = 1'b1; Feedback_Mem_Acc = 1'b0; Feedback_Branch = 1'b0;
    next_PC = 32'h0; Inst_Req_Ready = 1'b1; Inst_Valid = 1'b0; Instruction = 32'h0;
    rst_v = 1'b0; ordy_v = 1'b1; acc_v = 1'b0; br_v = 1'b0; hold_v = 1'b0; rrdy_v = 1'b1;
    tgt_v = 32'h0;
    model_clear();

    repeat (3) cycle();
    #2;
    chk("rst_pc", PC, 32'h0);
    chk("rst_done", {31'b0, Done_O}, 32'd0);
    chk("rst_req", {31'b0, Inst_Req_Valid}, 32'd0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_irpc", IR_PC, 32'h0);

    // Streaming with 1-cycle memory.
    rst_v = 1'b1;
    repeat (12) cycle();
    chk("stream_cnt", deliv.size(), 32'd10);
    chk("stream0", deliv[0], 32'h0);
    chk("stream1", deliv[1], 32'h4);
    chk("stream9", deliv[9], 32'h24);

    // Decode stall fills the queue.
    ordy_v = 1'b0;
    repeat (10) cycle();
    #2;
    chk("full_cnt", buf_q.size(), 32'd4);
    chk("full_head", IR_PC, 32'h28);
    chk("full_req", {31'b0, Inst_Req_Valid}, 32'd0);
    ordy_v = 1'b1;
    repeat (4) cycle();

    // Branch with two requests in flight.
    hold_v = 1'b1;
    repeat (6) cycle();
    #2;
    chk("hold_req", {31'b0, Inst_Req_Valid}, 32'd0);
    chk("hold_done", {31'b0, Done_O}, 32'd0);
    br_v = 1'b1; tgt_v = 32'h100;
    cycle();
    br_v = 1'b0; hold_v = 1'b0;
    mark = deliv.size();
    repeat (8) cycle();
    chk("br1_first", deliv[mark], 32'h100);
    chk("br1_second", deliv[mark+1], 32'h104);

    // Branch coinciding with an issue and a response.
    repeat (6) cycle();
    #2;
    chk("br2_req", {31'b0, Inst_Req_Valid}, 32'd1);
    br_v = 1'b1; tgt_v = 32'h200;
    cycle();
    br_v = 1'b0;
    mark = deliv.size();
    repeat (8) cycle();
    chk("br2_first", deliv[mark], 32'h200);

    // Shared memory busy: no issue, no pop.
    repeat (3) cycle();
    #2;
    ir0 = IR; pc0 = PC;
    acc_v = 1'b1;
    repeat (5) cycle();
    #2;
    chk("acc_ir", IR, ir0);
    chk("acc_pc", PC, pc0);
    chk("acc_done", {31'b0, Done_O}, 32'd1);
    acc_v = 1'b0;
    mark = deliv.size();
    repeat (6) cycle();
    chk("acc_resume", {31'b0, deliv.size() > mark}, 32'd1);

    // Asynchronous reset with a full queue.
    ordy_v = 1'b0;
    repeat (8) cycle();
    #2;
    chk("pre_rst_done", {31'b0, Done_O}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0; rst_v = 1'b0;
    #1;
    chk("arst_pc", PC, 32'h0);
    chk("arst_done", {31'b0, Done_O}, 32'd0);
    chk("arst_req", {31'b0, Inst_Req_Valid}, 32'd0);
    chk("arst_ir", IR, 32'h0);
    chk("arst_irpc", IR_PC, 32'h0);
    model_clear();
    repeat (2) cycle();
    rst_v = 1'b1; ordy_v = 1'b1;
    mark = deliv.size();
    repeat (6) cycle();
    chk("refetch0", deliv[mark], 32'h0);
    chk("refetch1", deliv[mark+1], 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stage_if_prefetch.md
# stage_if_prefetch

Parametrised instruction fetch stage with pipelined requests and a prefetch queue, sitting between the instruction memory port and decode. It keeps up to MAX_OUTSTANDING requests in flight, buffers returned instructions with their PCs in a QDEPTH-entry queue, and hands them to decode with a valid/ready handshake. On a branch it redirects the fetch PC, flushes the queue and silently discards responses still in flight. It supersedes the single-request IF FSM.

## Interface
- ADDR_W, 32, PC and next_PC width.
- INST_W, 32, instruction width.
- QDEPTH, 4, prefetch queue entries; power of two, ≥2.
- MAX_OUTSTANDING, 2, maximum requests in flight; 1..QDEPTH.
- RESET_PC, 0, first fetch address.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- PC  out  ADDR_W  request address (fetch PC register).
- Inst_Req_Valid  out  1  request valid.
- Inst_Req_Ready  in  1  memory accepts request.
- Instruction  in  INST_W  response data.
- Inst_Valid  in  1  response valid; responses return in request order.
- Inst_Ready  out  1  response accept.
- IR  out  INST_W  instruction presented to decode.
- IR_PC  out  ADDR_W  PC of IR.
- Done_O  out  1  IR/IR_PC valid.
- Out_Ready  in  1  decode accepts IR.
- next_PC  in  ADDR_W  branch target.
- Feedback_Branch  in  1  redirect/flush, one-cycle pulse.
- Feedback_Mem_Acc  in  1  shared memory busy: blocks request issue and pop.

## Operation
- Counters: count (queue occupancy), outstanding (requests accepted, response not yet received), discard (in-flight responses to drop); discard ≤ outstanding always.
- Issue: Inst_Req_Valid = !Feedback_Mem_Acc && outstanding < MAX_OUTSTANDING && count + outstanding < QDEPTH. Handshake (valid && ready): push PC into tag FIFO, PC <= PC + 4, outstanding++.
- Inst_Ready = 1 whenever not in reset; queue space is reserved at issue, so no overflow possible.
- Response (Inst_Valid && Inst_Ready): outstanding--, pop tag FIFO; if discard > 0 then discard--, data dropped; else push {Instruction, tag} into queue.
- Pop: Done_O && Out_Ready && !Feedback_Mem_Acc.
- Flush (Feedback_Branch): PC <= next_PC; count <= 0; discard <= outstanding after this cycle's issue/response updates (same-cycle request counted in, same-cycle response counted out); same-cycle live response and pop are lost; tag FIFO is not flushed (tags pop with discarded responses). Flush wins over every other event.
- Arithmetic: PC + 4 wraps modulo 2^ADDR_W; counters sized $clog2(QDEPTH+1), never wrap.

## Timing
- Reset values: PC = RESET_PC, IR = 0, IR_PC = 0, Done_O = 0, Inst_Req_Valid = 0, all counters 0.
- First request: Inst_Req_Valid = 1 in first cycle after rst deasserts.
- Latency (no bypass): response accepted in cycle t → Done_O = 1 in t+1 (queue empty, no flush).
- Throughput: one instruction/cycle when memory returns one response/cycle and MAX_OUTSTANDING ≥ memory latency.
- Branch in cycle t: request at next_PC issuable in t+1; no pre-branch instruction appears on Done_O from t+1 onward.
- Reset asserted mid-operation clears everything immediately; responses to pre-reset requests arriving afterwards are not tracked (memory is reset together).
- Queue full with outstanding = 0: Inst_Req_Valid = 0 until a pop.

## Configuration
- IF_QUEUE_BYPASS_EN defined: when queue empty (or count will be 0) and a live response arrives, Instruction/tag drive IR/IR_PC combinationally with Done_O = 1 that cycle; if popped, it is not written to the queue. Zero-cycle latency.
- Undefined: every instruction passes through the queue; one-cycle latency as above.

## Structure
- Shared package: ADDR_W/INST_W defaults, RESET_PC, the instruction-step constant 4.
- Sub-module if_fifo (parametrised width/depth, push/pop/flush, count): instantiated as prefetch queue (INST_W+ADDR_W, QDEPTH) and tag FIFO (ADDR_W, MAX_OUTSTANDING).

## Test plan
- Reset release, memory latency 1, Out_Ready = 1 → PCs 0,4,8,... issued back to back; IR/IR_PC stream in order, Done_O continuous.
- Out_Ready = 0 for 10 cycles → exactly QDEPTH (4) entries buffered, Inst_Req_Valid = 0, count + outstanding ≤ 4.
- Branch to 0x100 with 2 outstanding → both responses dropped, next Done_O shows IR_PC = 0x100.
- Branch same cycle as request handshake and response → discard = 1, first delivered IR_PC = next_PC.
- Feedback_Mem_Acc held 5 cycles → no new requests, Done_O held, IR unchanged; resumes after deassert.
- Reset asserted with queue full → all outputs return to reset values asynchronously; refetch from RESET_PC.
